// File: rtl/sync_mod_counter.sv
// rtl/sync_mod_counter.sv - modulo-N up/down counter with load, clear, wrap/saturate, tc pulse and sticky ovf
// Optional prescaler built only when CNT_PRESCALE_EN is defined.
module sync_mod_counter #(
  parameter int width_cnt = 26,
  parameter int mod_val   = 50000000,
  parameter int presc_div = 1
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 clr,
  input  logic                 load,
  input  logic [width_cnt-1:0] load_val,
  input  logic                 cnt_en,
  input  logic                 cnt_frw,
  input  logic                 mode_sat,
  input  logic                 ovf_clr,
  output logic [width_cnt-1:0] out,
  output logic                 tc,
  output logic                 ovf
);

  localparam logic [width_cnt-1:0] max_val = width_cnt'(mod_val - 1);
  // One extra bit so mod_val == 2**width_cnt is representable for the load clamp.
  localparam logic [width_cnt:0]   mod_ext = (width_cnt + 1)'(mod_val);

  logic                 step_tick;
  logic                 step_en;
  logic                 at_bnd;
  logic                 bnd_evt;
  logic [width_cnt-1:0] load_clamped;
  logic [width_cnt-1:0] next_step;

`ifdef CNT_PRESCALE_EN
  localparam int presc_w = (presc_div > 1) ? $clog2(presc_div) : 1;
  localparam logic [presc_w-1:0] presc_last = presc_w'(presc_div - 1);

  logic [presc_w-1:0] presc;

  assign step_tick = (presc == presc_last);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      presc <= '0;
    end else if (clr || load) begin
      presc <= '0;
    end else if (cnt_en) begin
      presc <= step_tick ? '0 : presc + 1'b1;
    end
  end
`else
  // Legal presc_div is always >= 1, so every enabled cycle is a step.
  assign step_tick = (presc_div >= 1);
`endif

  assign step_en      = cnt_en & ~clr & ~load & step_tick;
  assign at_bnd       = cnt_frw ? (out == max_val) : (out == '0);
  assign bnd_evt      = step_en & at_bnd;
  assign load_clamped = ({1'b0, load_val} >= mod_ext) ? max_val : load_val;

  always_comb begin
    next_step = out;
    if (cnt_frw) begin
      if (!at_bnd)       next_step = out + 1'b1;
      else if (!mode_sat) next_step = '0;
    end else begin
      if (!at_bnd)       next_step = out - 1'b1;
      else if (!mode_sat) next_step = max_val;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (clr) begin
        out <= '0;
        tc  <= 1'b0;
      end else if (load) begin
        out <= load_clamped;
        tc  <= 1'b0;
      end else if (step_en) begin
        out <= next_step;
        tc  <= at_bnd;
      end else begin
        tc  <= 1'b0;
      end
      // A boundary event on the same edge as ovf_clr keeps the flag set.
      if (bnd_evt) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule
